// File: rtl/jump_ctrl.sv
// Jump controller: turns arrow-key presses into jump/fail commands for the sprite block,
// tracks score and game over. Define JUMP_SPEEDUP_EN to shrink the reaction timeout as score grows.
module jump_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 80_000_000,
`ifdef JUMP_SPEEDUP_EN
  parameter int unsigned TIMEOUT_STEP   = 4_000_000,
  parameter int unsigned TIMEOUT_MIN    = 20_000_000,
  parameter int unsigned SPEEDUP_EVERY  = 10,
`endif
  parameter int unsigned SCORE_WIDTH    = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   module_en,
  input  logic                   key_left,
  input  logic                   key_right,
  input  logic                   next_block_side,
  input  logic                   landed,
  output logic                   jump_left,
  output logic                   jump_right,
  output logic                   jump_fail,
  output logic                   block_advance,
  output logic                   game_over,
  output logic [SCORE_WIDTH-1:0] score
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_WAIT_KEY, S_JUMP, S_FALL, S_OVER} state_e;

  state_e                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [TW-1:0]          timeout_lim;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic                   pend_valid_q, pend_valid_d, pend_side_q, pend_side_d;
  logic                   kl1_q, kl2_q, kr1_q, kr2_q;
  logic                   jump_left_q, jump_right_q, jump_fail_q, block_advance_q, game_over_q;
  logic                   jump_left_d, jump_right_d, jump_fail_d, block_advance_d;
  logic                   press_l, press_r, press_valid;
  logic                   eval_valid, eval_side;

  assign press_l     = kl1_q & ~kl2_q;
  assign press_r     = kr1_q & ~kr2_q;
  // Simultaneous left+right is treated as no press at all.
  assign press_valid = press_l ^ press_r;

  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    score_d         = score_q;
    pend_valid_d    = pend_valid_q;
    pend_side_d     = pend_side_q;
    jump_left_d     = 1'b0;
    jump_right_d    = 1'b0;
    jump_fail_d     = 1'b0;
    block_advance_d = 1'b0;
    eval_valid      = 1'b0;
    eval_side       = 1'b0;
    unique case (state_q)
      S_WAIT_KEY: begin
        timer_d = timer_q + TW'(1);
        if (pend_valid_q) begin
          eval_valid   = 1'b1;
          eval_side    = pend_side_q;
          pend_valid_d = 1'b0;
        end else begin
          eval_valid = press_valid;
          eval_side  = press_r;
        end
        if (eval_valid) begin
          timer_d = '0;
          if (eval_side == next_block_side) begin
            jump_right_d = eval_side;
            jump_left_d  = ~eval_side;
            state_d      = S_JUMP;
          end else begin
            jump_fail_d = 1'b1;
            state_d     = S_FALL;
          end
        end else if (timer_q == timeout_lim) begin
          timer_d     = '0;
          jump_fail_d = 1'b1;
          state_d     = S_FALL;
        end
      end
      S_JUMP: begin
        if (press_valid && !pend_valid_q) begin
          pend_valid_d = 1'b1;
          pend_side_d  = press_r;
        end
        if (landed) begin
          if (score_q != '1) score_d = score_q + SCORE_WIDTH'(1);
          block_advance_d = 1'b1;
          timer_d         = '0;
          state_d         = S_WAIT_KEY;
        end
      end
      S_FALL: begin
        pend_valid_d = 1'b0;
        if (landed) state_d = S_OVER;
      end
      S_OVER: begin
        pend_valid_d = 1'b0;
      end
    endcase
  end

`ifdef JUMP_SPEEDUP_EN
  logic [TW-1:0] timeout_q, timeout_d;

  always_comb begin
    timeout_d = timeout_q;
    if (state_q == S_JUMP && landed && score_q != '1 &&
        (score_d % SCORE_WIDTH'(SPEEDUP_EVERY)) == '0) begin
      if (32'(timeout_q) >= TIMEOUT_MIN + TIMEOUT_STEP) timeout_d = timeout_q - TW'(TIMEOUT_STEP);
      else timeout_d = TW'(TIMEOUT_MIN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !module_en) timeout_q <= TW'(TIMEOUT_CYCLES);
    else timeout_q <= timeout_d;
  end

  assign timeout_lim = timeout_q - TW'(1);
`else
  assign timeout_lim = TW'(TIMEOUT_CYCLES - 1);
`endif

  always_ff @(posedge clk) begin
    if (rst || !module_en) begin
      state_q         <= S_WAIT_KEY;
      timer_q         <= '0;
      score_q         <= '0;
      pend_valid_q    <= 1'b0;
      pend_side_q     <= 1'b0;
      // Preset to 1 so a key held across reset does not count as a press.
      kl1_q           <= 1'b1;
      kl2_q           <= 1'b1;
      kr1_q           <= 1'b1;
      kr2_q           <= 1'b1;
      jump_left_q     <= 1'b0;
      jump_right_q    <= 1'b0;
      jump_fail_q     <= 1'b0;
      block_advance_q <= 1'b0;
      game_over_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      score_q         <= score_d;
      pend_valid_q    <= pend_valid_d;
      pend_side_q     <= pend_side_d;
      kl1_q           <= key_left;
      kl2_q           <= kl1_q;
      kr1_q           <= key_right;
      kr2_q           <= kr1_q;
      jump_left_q     <= jump_left_d;
      jump_right_q    <= jump_right_d;
      jump_fail_q     <= jump_fail_d;
      block_advance_q <= block_advance_d;
      game_over_q     <= (state_d == S_OVER);
    end
  end

  assign jump_left     = jump_left_q;
  assign jump_right    = jump_right_q;
  assign jump_fail     = jump_fail_q;
  assign block_advance = block_advance_q;
  assign game_over     = game_over_q;
  assign score         = score_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Self-checking bench for jump_ctrl: expected pulses are queued with their due cycle and
// matched against the DUT's pulse outputs every cycle.
module tb_jump_ctrl;

  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          module_en = 1'b1;
  logic          key_left = 1'b0;
  logic          key_right = 1'b0;
  logic          next_block_side = 1'b0;
  logic          landed = 1'b0;
  logic          jump_left, jump_right, jump_fail, block_advance, game_over;
  logic [SW-1:0] score;

  jump_ctrl #(
    .TIMEOUT_CYCLES (100),
`ifdef JUMP_SPEEDUP_EN
    .TIMEOUT_STEP   (30),
    .TIMEOUT_MIN    (50),
    .SPEEDUP_EVERY  (2),
`endif
    .SCORE_WIDTH    (SW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .module_en       (module_en),
    .key_left        (key_left),
    .key_right       (key_right),
    .next_block_side (next_block_side),
    .landed          (landed),
    .jump_left       (jump_left),
    .jump_right      (jump_right),
    .jump_fail       (jump_fail),
    .block_advance   (block_advance),
    .game_over       (game_over),
    .score           (score)
  );

  always #5 clk = ~clk;

  // Pulse vector order: {jump_left, jump_right, jump_fail, block_advance}
  localparam logic [3:0] P_JL = 4'b1000;
  localparam logic [3:0] P_JR = 4'b0100;
  localparam logic [3:0] P_JF = 4'b0010;
  localparam logic [3:0] P_BA = 4'b0001;

  typedef struct {
    int         cyc;
    logic [3:0] pulses;
    string      tag;
  } exp_t;

  typedef struct {
    string      name;
    logic       side;
    logic       kl;
    logic       kr;
    logic [3:0] cmd;
    logic       ba;
    logic       over;
    int         score;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rst_cyc = 0;
  int   last_land = 0;

  function automatic void expect_pulse(logic [3:0] p, int at, string tag);
    exp_t e;
    e.cyc    = at;
    e.pulses = p;
    e.tag    = tag;
    exp_q.push_back(e);
  endfunction

  task automatic tick();
    logic [3:0] got;
    exp_t       e;
    @(posedge clk);
    #1;
    cyc++;
    got = {jump_left, jump_right, jump_fail, block_advance};
    if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (got !== e.pulses || e.cyc != cyc) begin
        errors++;
        $display("FAIL pulse_%s: got %b at cyc %0d, expected %b at cyc %0d",
                 e.tag, got, cyc, e.pulses, e.cyc);
      end
    end else if (got !== 4'b0000) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse: got %b at cyc %0d, expected 0000", got, cyc);
    end
  endtask

  task automatic drain(string phase);
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_%s (%s): got nothing by cyc %0d, expected %b at cyc %0d",
               e.tag, phase, cyc, e.pulses, e.cyc);
    end
  endtask

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst_cyc = cyc;
    rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_jump();
    next_block_side = 1'b1;
    key_right = 1'b1;
    expect_pulse(P_JR, cyc + 2, "jump_r");
    tick();
    tick();
    key_right = 1'b0;
    tick();
    landed = 1'b1;
    expect_pulse(P_BA, cyc + 1, "advance");
    tick();
    landed = 1'b0;
    last_land = cyc;
    tick();
  endtask

  task automatic wait_until(int target);
    while (cyc < target) tick();
  endtask

  initial begin
    vecs[0] = '{"right_match", 1'b1, 1'b0, 1'b1, P_JR,    1'b1, 1'b0, 1};
    vecs[1] = '{"left_match",  1'b0, 1'b1, 1'b0, P_JL,    1'b1, 1'b0, 1};
    vecs[2] = '{"right_wrong", 1'b0, 1'b0, 1'b1, P_JF,    1'b0, 1'b1, 0};
    vecs[3] = '{"left_wrong",  1'b1, 1'b1, 1'b0, P_JF,    1'b0, 1'b1, 0};
    vecs[4] = '{"both_side0",  1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 0};
    vecs[5] = '{"both_side1",  1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 0};

    // Reset state
    do_reset();
    check("reset_outputs", int'({jump_left, jump_right, jump_fail, block_advance, game_over}), 0);
    check("reset_score", int'(score), 0);

    // Table: press, land 50 cycles later, check score / game_over
    for (int i = 0; i < 6; i++) begin
      key_left = 1'b0;
      key_right = 1'b0;
      do_reset();
      next_block_side = vecs[i].side;
      key_left = vecs[i].kl;
      key_right = vecs[i].kr;
      if (vecs[i].cmd != 4'b0000) expect_pulse(vecs[i].cmd, cyc + 2, vecs[i].name);
      repeat (3) tick();
      key_left = 1'b0;
      key_right = 1'b0;
      repeat (47) tick();
      landed = 1'b1;
      if (vecs[i].ba) expect_pulse(P_BA, cyc + 1, {vecs[i].name, "_adv"});
      tick();
      landed = 1'b0;
      repeat (2) tick();
      check({vecs[i].name, "_score"}, int'(score), vecs[i].score);
      check({vecs[i].name, "_over"}, int'(game_over), int'(vecs[i].over));
      drain(vecs[i].name);
    end

    // Game over holds and further keys / landed produce nothing
    do_reset();
    next_block_side = 1'b0;
    key_right = 1'b1;
    expect_pulse(P_JF, cyc + 2, "fail_wrong");
    repeat (3) tick();
    key_right = 1'b0;
    repeat (2) tick();
    landed = 1'b1;
    tick();
    landed = 1'b0;
    tick();
    check("over_set", int'(game_over), 1);
    for (int i = 0; i < 3; i++) begin
      key_left = 1'b1;
      repeat (3) tick();
      key_left = 1'b0;
      key_right = 1'b1;
      landed = 1'b1;
      tick();
      landed = 1'b0;
      repeat (2) tick();
      key_right = 1'b0;
      repeat (2) tick();
    end
    check("over_held", int'(game_over), 1);
    check("over_score", int'(score), 0);
    drain("over");

    // Timeout: no key -> fail exactly 100 cycles after reset
    do_reset();
    expect_pulse(P_JF, rst_cyc + 100, "timeout");
    wait_until(rst_cyc + 102);
    drain("timeout");

    // Press evaluated in the last timeout cycle wins over the timeout
    do_reset();
    next_block_side = 1'b1;
    wait_until(rst_cyc + 98);
    key_right = 1'b1;
    expect_pulse(P_JR, rst_cyc + 100, "press_at_99");
    wait_until(rst_cyc + 103);
    key_right = 1'b0;
    check("press_at_99_over", int'(game_over), 0);
    drain("press_at_99");

    // Buffered press: first press in S_JUMP kept, second dropped
    do_reset();
    next_block_side = 1'b1;
    key_right = 1'b1;
    expect_pulse(P_JR, cyc + 2, "pend_first");
    repeat (2) tick();
    key_right = 1'b0;
    repeat (2) tick();
    key_left = 1'b1;
    repeat (2) tick();
    key_left = 1'b0;
    tick();
    key_right = 1'b1;
    repeat (2) tick();
    key_right = 1'b0;
    repeat (5) tick();
    next_block_side = 1'b0;
    landed = 1'b1;
    expect_pulse(P_BA, cyc + 1, "pend_adv");
    expect_pulse(P_JL, cyc + 2, "pend_left");
    tick();
    landed = 1'b0;
    repeat (5) tick();
    check("pend_score", int'(score), 1);
    drain("pending");

    // Key held across rst and module_en toggle generates no press
    next_block_side = 1'b1;
    key_right = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (6) tick();
    module_en = 1'b0;
    repeat (2) tick();
    check("disabled_outputs", int'({jump_left, jump_right, jump_fail, game_over}), 0);
    module_en = 1'b1;
    repeat (6) tick();
    key_right = 1'b0;
    repeat (2) tick();
    key_right = 1'b1;
    expect_pulse(P_JR, cyc + 2, "after_release");
    repeat (3) tick();
    key_right = 1'b0;
    repeat (2) tick();
    drain("held_key");

    // Reset in the middle of a jump
    do_reset();
    do_jump();
    check("mid_pre_score", int'(score), 1);
    key_right = 1'b1;
    expect_pulse(P_JR, cyc + 2, "mid_jump");
    repeat (2) tick();
    key_right = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_score", int'(score), 0);
    check("mid_rst_over", int'(game_over), 0);
    tick();
    landed = 1'b1;
    tick();
    landed = 1'b0;
    tick();
    check("mid_landed_ignored", int'(score), 0);
    key_right = 1'b1;
    expect_pulse(P_JR, cyc + 2, "mid_after_rst");
    repeat (3) tick();
    key_right = 1'b0;
    repeat (2) tick();
    drain("mid_rst");

    // Score saturates at all-ones
    do_reset();
    repeat (17) do_jump();
    check("score_saturate", int'(score), 15);
    drain("saturate");

`ifdef JUMP_SPEEDUP_EN
    begin
      int sp_n[4] = '{1, 2, 4, 6};
      int sp_t[4] = '{100, 70, 50, 50};
      for (int i = 0; i < 4; i++) begin
        do_reset();
        repeat (sp_n[i]) do_jump();
        check("speedup_score", int'(score), sp_n[i]);
        expect_pulse(P_JF, last_land + sp_t[i], "speedup_timeout");
        wait_until(last_land + sp_t[i] + 2);
        drain("speedup");
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jump_ctrl.md
Name: jump_ctrl

Overview:
- Game-logic stage directly upstream of the character sprite block.
- Turns keyboard left/right presses plus the side of the next platform into single-cycle jump_left / jump_right / jump_fail commands.
- Waits for the sprite's landed pulse, then updates the score, requests the next platform and, after a fall, flags game over.
- Enforces a per-jump reaction timeout.

Parameters:
- TIMEOUT_CYCLES, 80_000_000: clk cycles allowed in S_WAIT_KEY before an automatic fail (2 s at 40 MHz).
- SCORE_WIDTH, 14: width of the score counter.
- TIMEOUT_STEP, 4_000_000: timeout decrement per speed-up, used only with JUMP_SPEEDUP_EN.
- TIMEOUT_MIN, 20_000_000: timeout floor, used only with JUMP_SPEEDUP_EN.
- SPEEDUP_EVERY, 10: successful jumps per speed-up, used only with JUMP_SPEEDUP_EN.

Ports:
- clk  in  1  40 MHz clock
- rst  in  1  synchronous, active-high reset
- module_en  in  1  0 = hold block in reset state
- key_left  in  1  level, left arrow held
- key_right  in  1  level, right arrow held
- next_block_side  in  1  0 = next platform left, 1 = right
- landed  in  1  one-cycle pulse from the character block, end of jump or fall
- jump_left  out  1  one-cycle command
- jump_right  out  1  one-cycle command
- jump_fail  out  1  one-cycle command
- block_advance  out  1  one-cycle pulse: map shifts to the next platform
- game_over  out  1  level, high in S_OVER
- score  out  SCORE_WIDTH  successful jump count

Behaviour:
- Reset: clk is the clock; reset rst is synchronous, active-high. rst=1 or module_en=0 at a clk edge forces:
  - state=S_WAIT_KEY, timer=0, score=0, pending empty
  - all outputs 0
  - edge-detect registers k1/k2 set to 1, so a key held across reset or enable generates no press.
- Edge detect:
  - k1<=key, k2<=k1; press_x = k1 & ~k2.
  - press_l and press_r in the same cycle: both ignored.
  - All outputs are registered. A jump/fail pulse appears on the 2nd rising edge after key is first sampled high.
- Pulses: jump_left/right/fail and block_advance are each high exactly 1 cycle. At most one of the three jump commands is high in any cycle.
- States:
  - S_WAIT_KEY: timer increments each cycle.
    - Valid press matching next_block_side (left&0 or right&1): emit jump_left/jump_right, go to S_JUMP, timer=0.
    - Non-matching press: emit jump_fail, go to S_FALL.
    - Else if timer==timeout-1: emit jump_fail, go to S_FALL.
    - A press in the timeout cycle takes priority over the timeout.
    - A pending buffered press is evaluated as a fresh press on the first S_WAIT_KEY cycle and is then cleared.
  - S_JUMP:
    - First press seen is stored in a 1-deep pending buffer (side bit + valid). Later presses are dropped.
    - On landed: score+1 (saturates at all-ones, no wrap), block_advance=1 in the same registered cycle, go to S_WAIT_KEY, timer=0.
  - S_FALL: presses ignored, pending cleared. On landed: go to S_OVER.
  - S_OVER: game_over=1. Stays until rst or module_en=0.
- landed outside S_JUMP/S_FALL is ignored.
- timer width = ceil(log2(TIMEOUT_CYCLES+1)).
- next_block_side is sampled in the cycle the press is evaluated.

Optional Feature:
- JUMP_SPEEDUP_EN defined:
  - Effective timeout register starts at TIMEOUT_CYCLES.
  - Each time score reaches a multiple of SPEEDUP_EVERY (on the block_advance cycle), timeout = max(timeout-TIMEOUT_STEP, TIMEOUT_MIN).
  - Reset restores TIMEOUT_CYCLES.
- Undefined: timeout is constant TIMEOUT_CYCLES. No step logic is synthesized.

Test Plan (bench uses TIMEOUT_CYCLES=100):
- next_block_side=1, key_right rises -> jump_right 1-cycle pulse 2 edges later. Landed pulse 50 cycles later -> score 0->1, block_advance 1 cycle, state S_WAIT_KEY.
- next_block_side=0, key_right press -> jump_fail pulse, no jump_left/right. Landed -> game_over=1 and held. Further keys -> no outputs.
- No key for 100 cycles in S_WAIT_KEY -> jump_fail on cycle 100. Press arriving exactly at cycle 99 -> jump command instead of fail.
- Press left during S_JUMP, then right → after landed with next_block_side=0 -> jump_left issued within 2 cycles, right press discarded.
- key_right held through rst and module_en toggle -> no jump command until released and pressed again. Both keys rising same cycle -> nothing. Mid-jump rst -> score=0, state S_WAIT_KEY.
- With JUMP_SPEEDUP_EN, TIMEOUT_STEP=30, TIMEOUT_MIN=50, SPEEDUP_EVERY=2 -> after score 2 timeout is 70, after score 4 timeout is 50, after score 6 timeout stays 50. Check fail cycles match.
